// File: rtl/ram_share_arbiter.sv
// ram_share_arbiter: two req/ack clients share one single-port RAM through an IDLE/ACCESS/DONE sequencer.
// Optional feature macro RAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise port 0 has fixed priority.
module ram_share_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              ack_0,
  output logic              ack_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                grant_r;
  logic                last_grant;
  logic                elig_0;
  logic                elig_1;
  logic                any_elig;
  logic                win;

  // A port whose ack is high this cycle is still presenting the request that just completed.
  always_comb begin
    elig_0   = req_0 & ~ack_0;
    elig_1   = req_1 & ~ack_1;
    any_elig = elig_0 | elig_1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (elig_0 && elig_1) win = ~last_grant;
    else if (elig_0)      win = 1'b0;
    else if (elig_1)      win = 1'b1;
    else                  win = last_grant;
`else
    if (elig_0)           win = 1'b0;
    else if (elig_1)      win = 1'b1;
    else                  win = last_grant;
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_elig) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode from the async-reset state register, so they drop the moment rst_n falls.
  always_comb begin
    ram_wr    = (state == ACCESS) &  we_r;
    ram_rd    = (state == ACCESS) & ~we_r;
    ram_addr  = addr_r;
    ram_wdata = wdata_r;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      grant_r    <= 1'b0;
      last_grant <= 1'b1;
      ack_0      <= 1'b0;
      ack_1      <= 1'b0;
      rdata_0    <= '0;
      rdata_1    <= '0;
    end else begin
      state <= state_next;
      ack_0 <= 1'b0;
      ack_1 <= 1'b0;
      if (state == IDLE && any_elig) begin
        grant_r    <= win;
        last_grant <= win;
        we_r       <= win ? we_1    : we_0;
        addr_r     <= win ? addr_1  : addr_0;
        wdata_r    <= win ? wdata_1 : wdata_0;
      end
      // RAM read data registered at the ACCESS edge is captured here.
      if (state == DONE) begin
        if (grant_r) begin
          ack_1 <= 1'b1;
          if (!we_r) rdata_1 <= ram_rdata;
        end else begin
          ack_0 <= 1'b1;
          if (!we_r) rdata_0 <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_share_arbiter.sv
// Bench for ram_share_arbiter: behavioural RAM, timeline-based reference model, directed table plus random traffic.
module tb_ram_share_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_0, req_1, we_0, we_1;
  logic [AW-1:0] addr_0, addr_1;
  logic [DW-1:0] wdata_0, wdata_1;
  logic          ack_0, ack_1;
  logic [DW-1:0] rdata_0, rdata_1;
  logic          ram_wr, ram_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;
  logic          ram_clr;

  always #5 clk = ~clk;

  ram_share_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .ack_0(ack_0), .ack_1(ack_1), .rdata_0(rdata_0), .rdata_1(rdata_1),
    .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  // Single-port RAM: synchronous write, one-cycle registered read.
  logic [DW-1:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
    end else begin
      if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
      if (ram_rd) ram_rdata <= ram_mem[ram_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a granted transaction occupies edges t (grant), t+1 (RAM access), t+2 (ack).
  logic [DW-1:0] m_mem [16];
  int            edge_no = 0;
  bit            m_active;
  int            m_t;
  int            m_port;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_last;
  bit            m_ack [2];
  logic [DW-1:0] m_rdata [2];
  bit            m_wr, m_rd;
  int            grant_log [$];
  int            ack_cnt [2];

  function automatic void model_reset();
    m_active = 0; m_last = 1;
    m_ack[0] = 0; m_ack[1] = 0;
    m_rdata[0] = '0; m_rdata[1] = '0;
    m_wr = 0; m_rd = 0;
    m_addr = '0; m_wdata = '0; m_we = 0;
  endfunction

  function automatic void model_edge();
    bit pa0, pa1, e0, e1;
    int w;
    pa0 = m_ack[0]; pa1 = m_ack[1];
    m_ack[0] = 0; m_ack[1] = 0;
    edge_no++;
    if (m_active && edge_no == m_t + 2) begin
      m_ack[m_port] = 1;
      if (!m_we) m_rdata[m_port] = m_mem[m_addr];
      m_active = 0;
    end else if (m_active && edge_no == m_t + 1) begin
      if (m_we) m_mem[m_addr] = m_wdata;
      m_wr = 0; m_rd = 0;
    end else if (!m_active) begin
      e0 = req_0 && !pa0;
      e1 = req_1 && !pa1;
      if (e0 || e1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        if (e0 && e1) w = 1 - m_last;
        else          w = e1 ? 1 : 0;
`else
        w = e0 ? 0 : 1;
`endif
        m_active = 1; m_t = edge_no; m_port = w; m_last = w;
        m_we    = (w == 1) ? we_1    : we_0;
        m_addr  = (w == 1) ? addr_1  : addr_0;
        m_wdata = (w == 1) ? wdata_1 : wdata_0;
        m_wr = m_we; m_rd = !m_we;
        grant_log.push_back(w);
      end
    end
  endfunction

  function automatic void compare_outputs();
    check("ack_0", 32'(ack_0), 32'(m_ack[0]));
    check("ack_1", 32'(ack_1), 32'(m_ack[1]));
    check("rdata_0", 32'(rdata_0), 32'(m_rdata[0]));
    check("rdata_1", 32'(rdata_1), 32'(m_rdata[1]));
    check("ram_wr", 32'(ram_wr), 32'(m_wr));
    check("ram_rd", 32'(ram_rd), 32'(m_rd));
    check("ram_addr", 32'(ram_addr), 32'(m_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
    check("busy", 32'(busy), 32'(m_active));
  endfunction

  task automatic cycle();
    @(posedge clk); #1;
    model_edge();
    compare_outputs();
    if (ack_0) ack_cnt[0]++;
    if (ack_1) ack_cnt[1]++;
  endtask

  task automatic drive(input int p, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req_0 = r; we_0 = w; addr_0 = a; wdata_0 = d; end
    else        begin req_1 = r; we_1 = w; addr_1 = a; wdata_1 = d; end
  endtask

  function automatic logic dut_ack(input int p);
    return (p == 0) ? ack_0 : ack_1;
  endfunction

  function automatic logic [DW-1:0] dut_rdata(input int p);
    return (p == 0) ? rdata_0 : rdata_1;
  endfunction

  // One access from an idle arbiter; lat counts edges from request to visible ack.
  task automatic access(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
    lat = -1;
    drive(p, 1'b1, w, a, d);
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (dut_ack(p)) begin lat = k; break; end
    end
    drive(p, 1'b0, w, a, d);
    if (lat < 0) check("access_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int lat, n, first, base, loser;
    int ack_cyc [$];
    int dut_log [$];
    logic [DW-1:0] prev;
    logic [DW-1:0] keep1;

    vecs[0] = '{0, 1'b1, 4'd3,  8'hA5, 8'h00};
    vecs[1] = '{0, 1'b0, 4'd3,  8'h00, 8'hA5};
    vecs[2] = '{1, 1'b1, 4'd15, 8'h3C, 8'h00};
    vecs[3] = '{0, 1'b1, 4'd0,  8'hC3, 8'h00};
    vecs[4] = '{0, 1'b0, 4'd15, 8'h00, 8'h3C};
    vecs[5] = '{1, 1'b0, 4'd0,  8'h00, 8'hC3};

    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    rst_n = 1'b0; ram_clr = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs();
    rst_n = 1'b1; ram_clr = 1'b0;
    cycle();

    // Directed table: each access from idle, one spare cycle between accesses.
    for (int i = 0; i < 6; i++) begin
      prev = dut_rdata(vecs[i].port);
      access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
      check("vec_latency", 32'(lat), 32'd3);
      if (vecs[i].we) check("vec_wr_rdata_hold", 32'(dut_rdata(vecs[i].port)), 32'(prev));
      else            check("vec_rdata", 32'(dut_rdata(vecs[i].port)), 32'(vecs[i].exp_rdata));
      if (i == 1) check("ack_1_silent", 32'(ack_cnt[1]), 32'd0);
      cycle();
    end

    // Tie from idle after port 0 was the last winner.
    access(0, 1'b0, 4'd3, 8'h00, lat);
    cycle();
    drive(0, 1'b1, 1'b0, 4'd3, 8'h00);
    drive(1, 1'b1, 1'b0, 4'd15, 8'h00);
    first = -1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (ack_0 || ack_1) begin first = ack_1 ? 1 : 0; break; end
    end
`ifdef RAM_ARB_ROUND_ROBIN_EN
    check("tie_winner", 32'(first), 32'd1);
`else
    check("tie_winner", 32'(first), 32'd0);
`endif
    loser = (first == 1) ? 0 : 1;
    drive(first < 0 ? 0 : first, 1'b0, 1'b0, '0, '0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (dut_ack(loser)) begin n = 1; break; end
    end
    check("tie_loser_served", 32'(n), 32'd1);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    cycle(); cycle();

    // Both ports stream writes; ack order must follow the model's grant order.
    base = grant_log.size();
    drive(0, 1'b1, 1'b1, 4'd8,  8'h10);
    drive(1, 1'b1, 1'b1, 4'd12, 8'h20);
    for (int k = 0; k < 40 && dut_log.size() < 4; k++) begin
      cycle();
      if (ack_0) begin dut_log.push_back(0); drive(0, 1'b1, 1'b1, 4'(8 + dut_log.size()),  8'(8'h10 + dut_log.size())); end
      if (ack_1) begin dut_log.push_back(1); drive(1, 1'b1, 1'b1, 4'(12 + dut_log.size()), 8'(8'h20 + dut_log.size())); end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    check("stream_grants", 32'(dut_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < dut_log.size() && base + i < grant_log.size(); i++)
      check("stream_order", 32'(dut_log[i]), 32'(grant_log[base + i]));
    repeat (4) cycle();
    for (int i = 0; i < 16; i++) check("ram_contents", 32'(ram_mem[i]), 32'(m_mem[i]));

    // Five back-to-back reads from port 0 with req held.
    n = 0;
    drive(0, 1'b1, 1'b0, 4'd8, 8'h00);
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (ack_0) begin
        ack_cyc.push_back(k); n++;
        if (n == 5) drive(0, 1'b0, 1'b0, '0, '0);
        else        drive(0, 1'b1, 1'b0, 4'(8 + n), 8'h00);
      end
    end
    check("five_reads_count", 32'(n), 32'd5);
    for (int i = 2; i < ack_cyc.size(); i++)
      check("five_reads_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(ack_cyc[1] - ack_cyc[0]));
    if (ack_cyc.size() > 1) check("five_reads_no_dup", 32'(ack_cyc[1] - ack_cyc[0] > 2), 32'd1);

    // Port 0 read of addr 7 while port 1 wiggles addr_1 with req low.
    access(1, 1'b1, 4'd7, 8'h77, lat);
    cycle();
    keep1 = rdata_1;
    drive(0, 1'b1, 1'b0, 4'd7, 8'h00);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (ram_rd) check("inflight_addr", 32'(ram_addr), 32'd7);
      addr_1 = 4'($urandom_range(15));
      if (ack_0) begin n = 1; break; end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    check("inflight_ack", 32'(n), 32'd1);
    check("inflight_rdata_0", 32'(rdata_0), 32'h77);
    check("inflight_rdata_1", 32'(rdata_1), 32'(keep1));
    cycle();

    // Reset during the ACCESS cycle of a write.
    access(0, 1'b1, 4'd5, 8'h00, lat);
    cycle();
    drive(0, 1'b1, 1'b1, 4'd5, 8'hFF);
    cycle();
    check("rst_pre_wr", 32'(ram_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_wr_async", 32'(ram_wr), 32'd0);
    compare_outputs();
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    compare_outputs();
    rst_n = 1'b1;
    cycle();
    access(0, 1'b0, 4'd5, 8'h00, lat);
    check("rst_no_commit", 32'(rdata_0), 32'h00);
    cycle();

    // Random traffic from two protocol-following requesters.
    for (int k = 0; k < 800; k++) begin
      cycle();
      for (int p = 0; p < 2; p++) begin
        if ((p == 0 && req_0) || (p == 1 && req_1)) begin
          if (dut_ack(p)) begin
            if ($urandom_range(1) == 1)
              drive(p, 1'b1, 1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom_range(255)));
            else
              drive(p, 1'b0, 1'b0, '0, '0);
          end
        end else if ($urandom_range(2) == 0) begin
          drive(p, 1'b1, 1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom_range(255)));
        end
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (6) cycle();
    for (int i = 0; i < 16; i++) check("final_ram", 32'(ram_mem[i]), 32'(m_mem[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
